// File: rtl/ura_scoreboard.sv
// ura_scoreboard: decode-stage hazard scoreboard keyed on unified register address.
// Optional stall counter output enabled by URA_SCOREBOARD_STATS_EN.
module ura_scoreboard #(
    parameter int URA_W     = 7,
    parameter int SRC_PORTS = 2,
    parameter int DEPTH     = 3,
    parameter int T_W       = 2,
    localparam int FS_W     = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    input  logic [URA_W-1:0]           issue_dst_ura,
    input  logic [T_W-1:0]             issue_dst_tnew,
    input  logic [SRC_PORTS*URA_W-1:0] src_ura,
    input  logic [SRC_PORTS-1:0]       src_used,
    input  logic [SRC_PORTS*T_W-1:0]   src_tuse,
    input  logic                       flush,
    output logic                       stall,
    output logic [SRC_PORTS*FS_W-1:0]  fwd_sel,
    output logic [SRC_PORTS-1:0]       src_pending
`ifdef URA_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    typedef struct packed {
        logic             valid;
        logic [URA_W-1:0] ura;
        logic [T_W-1:0]   tnew;
    } slot_t;

    slot_t slots [DEPTH];

    logic             hit;
    logic [FS_W-1:0]  hit_fs;
    logic [T_W-1:0]   hit_tnew;
    logic [URA_W-1:0] cur_ura;

    // Per source: find the youngest matching producer and derive stall/forward/pending.
    always_comb begin
        stall       = 1'b0;
        fwd_sel     = '0;
        src_pending = '0;
        hit         = 1'b0;
        hit_fs      = '0;
        hit_tnew    = '0;
        cur_ura     = '0;
        for (int i = 0; i < SRC_PORTS; i++) begin
            hit      = 1'b0;
            hit_fs   = '0;
            hit_tnew = '0;
            cur_ura  = src_ura[i*URA_W +: URA_W];
            // Walk oldest to youngest so the youngest match overwrites older ones.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slots[k].valid && src_used[i] &&
                    (cur_ura != '0) && (slots[k].ura == cur_ura)) begin
                    hit      = 1'b1;
                    hit_fs   = FS_W'(k + 1);
                    hit_tnew = slots[k].tnew;
                end
            end
            if (hit) begin
                if (hit_tnew > src_tuse[i*T_W +: T_W]) begin
                    stall = 1'b1;
                end
                if (hit_tnew == '0) begin
                    fwd_sel[i*FS_W +: FS_W] = hit_fs;
                end else begin
                    src_pending[i] = 1'b1;
                end
            end
        end
    end

    // Shift the in-flight pipeline; a stalled, flushed or $zero write enters as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else begin
            slots[0].valid <= issue_valid & ~stall & (issue_dst_ura != '0);
            slots[0].ura   <= issue_dst_ura;
            slots[0].tnew  <= issue_dst_tnew;
            for (int k = 1; k < DEPTH; k++) begin
                slots[k].valid <= slots[k-1].valid;
                slots[k].ura   <= slots[k-1].ura;
                slots[k].tnew  <= (slots[k-1].tnew == '0) ?
                                  slots[k-1].tnew : slots[k-1].tnew - 1'b1;
            end
        end
    end

`ifdef URA_SCOREBOARD_STATS_EN
    // Count every edge on which decode is held; survives flush, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ura_scoreboard.sv
// tb_ura_scoreboard: directed scoreboard bench for ura_scoreboard.
// Expected outputs are queued with each stimulus step and popped when sampled.
module tb_ura_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [6:0]  issue_dst_ura;
    logic [1:0]  issue_dst_tnew;
    logic [13:0] src_ura;
    logic [1:0]  src_used;
    logic [3:0]  src_tuse;
    logic        flush;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [1:0]  src_pending;
`ifdef URA_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    ura_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_dst_ura  (issue_dst_ura),
        .issue_dst_tnew (issue_dst_tnew),
        .src_ura        (src_ura),
        .src_used       (src_used),
        .src_tuse       (src_tuse),
        .flush          (flush),
        .stall          (stall),
        .fwd_sel        (fwd_sel),
        .src_pending    (src_pending)
`ifdef URA_SCOREBOARD_STATS_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    typedef struct {
        string      tag;
        logic       stall;
        logic [3:0] fwd;
        logic [1:0] pend;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got no entry, need one");
            return;
        end
        e = q.pop_front();
        tests++;
        assert (stall === e.stall) else begin
            fails++;
            $error("FAIL %s.stall: got %b want %b", e.tag, stall, e.stall);
        end
        tests++;
        assert (fwd_sel === e.fwd) else begin
            fails++;
            $error("FAIL %s.fwd_sel: got %h want %h", e.tag, fwd_sel, e.fwd);
        end
        tests++;
        assert (src_pending === e.pend) else begin
            fails++;
            $error("FAIL %s.pend: got %b want %b", e.tag, src_pending, e.pend);
        end
    endtask

    task automatic step(input string tag,
                        input logic iv, input logic [6:0] dst, input logic [1:0] tn,
                        input logic [6:0] s0, input logic [6:0] s1,
                        input logic [1:0] used,
                        input logic [1:0] t0, input logic [1:0] t1,
                        input logic fl,
                        input logic es, input logic [3:0] ef, input logic [1:0] ep);
        exp_t e;
        @(negedge clk);
        issue_valid    = iv;
        issue_dst_ura  = dst;
        issue_dst_tnew = tn;
        src_ura        = {s1, s0};
        src_used       = used;
        src_tuse       = {t1, t0};
        flush          = fl;
        e.tag   = tag;
        e.stall = es;
        e.fwd   = ef;
        e.pend  = ep;
        q.push_back(e);
        #1;
        check_out();
    endtask

`ifdef URA_SCOREBOARD_STATS_EN
    task automatic check_cnt(input string tag, input logic [31:0] want);
        tests++;
        assert (stall_cycles === want) else begin
            fails++;
            $error("FAIL %s.stall_cycles: got %0d want %0d", tag, stall_cycles, want);
        end
    endtask
`endif

    initial begin
        reset          = 1'b0;
        issue_valid    = 1'b0;
        issue_dst_ura  = '0;
        issue_dst_tnew = '0;
        src_ura        = '0;
        src_used       = '0;
        src_tuse       = '0;
        flush          = 1'b0;

        // reset state
        step("reset", 0, 0, 0, 7'd8, 7'd9, 2'b11, 0, 0, 0, 0, 4'h0, 2'b00);
`ifdef URA_SCOREBOARD_STATS_EN
        check_cnt("reset", 32'd0);
`endif
        #1 reset = 1'b1;

        // 1: load-use stall
        step("lu_issue", 1, 7'd8, 2, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00);
        step("lu_stall", 1, 7'd10, 1, 7'd8, 0, 2'b01, 1, 0, 0, 1, 4'h0, 2'b01);
        step("lu_go", 1, 7'd10, 1, 7'd8, 0, 2'b01, 1, 0, 0, 0, 4'h0, 2'b01);
        step("lu_fwd3", 0, 0, 0, 7'd8, 0, 2'b01, 0, 0, 0, 0, 4'h3, 2'b00);
        step("lu_gone", 0, 0, 0, 7'd8, 0, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00);
        step("clr1", 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 4'h0, 2'b00);

        // 2: forward now, tracking slot index
        step("fw_issue", 1, 7'd9, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00);
        step("fw_s0", 0, 0, 0, 0, 7'd9, 2'b10, 0, 0, 0, 0, 4'h4, 2'b00);
        step("fw_s1", 0, 0, 0, 0, 7'd9, 2'b10, 0, 0, 0, 0, 4'h8, 2'b00);
        step("fw_s2", 0, 0, 0, 0, 7'd9, 2'b10, 0, 0, 0, 0, 4'hc, 2'b00);
        step("fw_out", 0, 0, 0, 0, 7'd9, 2'b10, 0, 0, 0, 0, 4'h0, 2'b00);

        // 3: $zero destination/source and unused port
        step("z_issue", 1, 7'd0, 2, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00);
        step("z_src", 1, 7'd12, 2, 7'd0, 0, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00);
        step("unused", 0, 0, 0, 7'd12, 7'd12, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00);
        step("used", 0, 0, 0, 7'd12, 0, 2'b01, 0, 0, 0, 1, 4'h0, 2'b01);
        step("clr3", 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 4'h0, 2'b00);

        // 4: youngest match shadows older ready producer
        step("hi_old", 1, 7'd64, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00);
        step("hi_new", 1, 7'd64, 2, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00);
        step("shadow0", 0, 0, 0, 7'd64, 7'd65, 2'b11, 0, 0, 0, 1, 4'h0, 2'b01);
        step("shadow1", 0, 0, 0, 7'd64, 7'd65, 2'b11, 0, 0, 0, 1, 4'h0, 2'b01);
        step("hi_fwd", 0, 0, 0, 7'd64, 7'd65, 2'b11, 0, 0, 0, 0, 4'h3, 2'b00);
        step("clr4", 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 4'h0, 2'b00);

        // 5: flush while stalled
        step("fl_issue", 1, 7'd33, 2, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00);
        step("fl_stall", 1, 7'd40, 1, 7'd33, 0, 2'b01, 0, 0, 0, 1, 4'h0, 2'b01);
        step("fl_edge", 1, 7'd40, 1, 7'd33, 0, 2'b01, 0, 0, 1, 1, 4'h0, 2'b01);
        step("fl_after", 1, 7'd40, 1, 7'd33, 7'd40, 2'b11, 0, 0, 0, 0, 4'h0, 2'b00);

        // 6: async reset mid-operation, then stall counting
        step("pre_rst", 0, 0, 0, 7'd40, 0, 2'b01, 0, 0, 0, 1, 4'h0, 2'b01);
        #1 reset = 1'b0;
        q.push_back('{tag: "rst_mid", stall: 1'b0, fwd: 4'h0, pend: 2'b00});
        #1 check_out();
        #1 reset = 1'b1;
        step("st_issue", 1, 7'd20, 3, 0, 0, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00);
        step("st_1", 0, 0, 0, 7'd20, 0, 2'b01, 0, 0, 0, 1, 4'h0, 2'b01);
        step("st_2", 0, 0, 0, 7'd20, 0, 2'b01, 0, 0, 0, 1, 4'h0, 2'b01);
        step("st_3", 0, 0, 0, 7'd20, 0, 2'b01, 0, 0, 0, 1, 4'h0, 2'b01);
        step("st_done", 1, 7'd20, 3, 7'd20, 0, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00);
`ifdef URA_SCOREBOARD_STATS_EN
        check_cnt("three", 32'd3);
`endif
        step("st_pend", 0, 0, 0, 7'd20, 0, 2'b01, 0, 0, 0, 1, 4'h0, 2'b01);
        #1 reset = 1'b0;
        q.push_back('{tag: "rst_fin", stall: 1'b0, fwd: 4'h0, pend: 2'b00});
        #1 check_out();
`ifdef URA_SCOREBOARD_STATS_EN
        check_cnt("rst_fin", 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ura_scoreboard.md
Name: ura_scoreboard

Overview:
- Parametrised hazard scoreboard keyed on URA (Unified Register Address): GRF {00,rs}, CP0 {01,rd}, HI 7'b1000000, LO 7'b1000001.
- Sits in the decode stage, after the RS/RT/destination URA decoders.
- Tracks in-flight writers in a shift pipeline of DEPTH slots and compares each source URA against them.
- Outputs the decode stall, a per-source "value ready now" forward select, and a per-source "producer still pending" flag.

Parameters:
URA_W, 7, width of one URA.
SRC_PORTS, 2, number of source operands checked per instruction.
DEPTH, 3, number of tracked in-flight slots (slot 0 is youngest).
T_W, 2, width of Tnew/Tuse fields in cycles.

Ports:
clk  input  1  clock, all state updates on the rising edge.
reset  input  1  reset: the block has one clock; reset is asynchronous and active-low.
issue_valid  input  1  decode holds a real instruction.
issue_dst_ura  input  URA_W  destination URA of that instruction.
issue_dst_tnew  input  T_W  cycles after issue until the result is forwardable.
src_ura  input  SRC_PORTS*URA_W  source URAs, port i at [i*URA_W +: URA_W].
src_used  input  SRC_PORTS  port i is a real operand.
src_tuse  input  SRC_PORTS*T_W  cycles after issue until port i is consumed.
flush  input  1  kill all in-flight slots.
stall  output  1  combinational; decode must hold.
fwd_sel  output  SRC_PORTS*FS_W  FS_W=$clog2(DEPTH+1); 0 means read the register file, k means take the value from slot k-1.
src_pending  output  SRC_PORTS  youngest matching producer has not produced yet.

Behaviour:
- Slot state: valid, ura, tnew.
- Reset (asynchronous, low): all slots invalid. Outputs then read stall=0, fwd_sel=0, src_pending=0.
- Each rising edge, unless reset is low:
  - Slot k+1 loads slot k with tnew saturating-decremented (0 stays 0).
  - The content of slot DEPTH-1 is discarded.
  - Slot 0 is loaded as follows:
    - valid=issue_valid & ~stall & ~flush & (issue_dst_ura!=0).
    - ura=issue_dst_ura.
    - tnew=issue_dst_tnew.
  - A stalled, flushed or zero-destination instruction inserts a bubble.
- flush=1: every slot is cleared to invalid on the next edge. flush takes priority over issue and over the shift.
- Match for port i: slot valid, src_used[i]=1, src_ura[i]!=0, and slot.ura==src_ura[i].
  - URA 0 ($zero) never matches.
  - HI, LO and CP0 URAs compare like any other value.
- Only the youngest matching slot (lowest index) is considered. Older matches are shadowed.
- Responses when a youngest match exists:
  - stall_i = youngest.tnew > src_tuse[i].
  - fwd_sel[i] = index+1 if youngest.tnew==0, else 0.
  - src_pending[i] = youngest.tnew!=0.
- No match: stall_i=0, fwd_sel=0, src_pending=0.
- stall = OR of stall_i over all ports. It does not depend on issue_valid.
- All outputs are purely combinational from slot state and inputs. There is no added latency.
- Simultaneous flush and matching slots: the outputs still reflect current slot state this cycle; the slots clear on the edge.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.

Optional Feature:
- Macro: URA_SCOREBOARD_STATS_EN.
- Defined:
  - Adds output stall_cycles (32 bits).
  - Increments on each edge where stall=1; wraps at 2^32.
  - Cleared by reset.
  - Not cleared by flush.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Load-use stall:
   - Stimulus: issue dst=7'd8, tnew=2. Next cycle, src0=7'd8, tuse=1.
   - Response: stall=1 for exactly 1 cycle. Then slot1.tnew=1, stall=0, src_pending[0]=1, fwd_sel[0]=0.
2. Forward now:
   - Stimulus: issue dst=7'd9, tnew=0. Next cycle, src1=7'd9, tuse=0.
   - Response: stall=0, fwd_sel[1]=1. One cycle later with the same source: fwd_sel[1]=2.
3. Zero register and unused port:
   - Stimulus: issue dst=0, tnew=2. Then src0=0. Separately, a match with src_used=0.
   - Response: stall=0, fwd_sel=0 in all cases. Slot 0 holds a bubble.
4. Youngest shadowing:
   - Stimulus: dst=7'd64 (HI) tnew=0, then dst=7'd64 tnew=2. Then src0=7'd64, tuse=0.
   - Response: stall=1 (younger slot wins). The older slot's tnew=0 is ignored.
5. Flush:
   - Stimulus: pending dst=7'd33 tnew=2, stall=1, then flush=1 for one cycle.
   - Response: next cycle all slots invalid, stall=0. The stalled instruction inserted nothing.
6. Async reset and stats:
   - Stimulus: 3 stall cycles with URA_SCOREBOARD_STATS_EN defined, then reset low mid-cycle.
   - Response: stall_cycles=3 before reset. After reset: stall=0, stall_cycles=0, with no clock edge needed.
